// File: rtl/serial_add_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_pkg
// Shared definitions for the bit-serial adder initiator:
//   - state_e        : driver FSM state encoding
//   - W_DEFAULT      : default operand/sum width
//   - BIT_CYC_DEFAULT: default clock cycles per bit window
//   - clog2()        : counter width helper (ceil(log2(n)))
// -----------------------------------------------------------------------------
package serial_add_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ARM   = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int W_DEFAULT       = 32'sd8;
  localparam int BIT_CYC_DEFAULT = 32'sd3;

  // Smallest r such that 2**r >= n; callers always pass n >= 2.
  function automatic int clog2(input int n);
    int r;
    r = 32'sd0;
    while ((32'sd1 << r) < n) begin
      r = r + 32'sd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ser_shift_reg.sv
// -----------------------------------------------------------------------------
// ser_shift_reg
// W-bit right shift register with parallel load. Serial data enters at the
// MSB and leaves at the LSB (q[0]). Load has priority over shift.
// Ports:
//   clk   in  1  clock
//   nrst  in  1  synchronous active-low reset (clears q)
//   load  in  1  parallel load of din
//   din   in  W  parallel load data
//   shift in  1  shift right by one, sin enters at the MSB
//   sin   in  1  serial input
//   q     out W  register contents (q[0] is the serial output)
// -----------------------------------------------------------------------------
module ser_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         shift,
  input  logic         sin,
  output logic [W-1:0] q
);

  logic [W-1:0] q_r;

  // Shift register storage: reset, parallel load, or right shift with MSB serial in
  always_ff @(posedge clk) begin
    if (!nrst) begin
      q_r <= '0;
    end else if (load) begin
      q_r <= din;
    end else if (shift) begin
      q_r <= {sin, q_r[W-1:1]};
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/serial_add_driver.sv
// -----------------------------------------------------------------------------
// serial_add_driver
// Initiator for one bit-serial adder slice. Takes two W-bit operands plus a
// carry-in over a valid/ready request port, clears and arms the slice, then
// feeds it one bit pair per BIT_CYC-cycle window, LSB first. The slice's
// registered sum bit and carry are sampled in the last cycle of every window;
// the carry is looped back onto slc_cin and the sum bits are reassembled into
// a parallel result held on the result port until res_ready.
//
// Optional build macro:
//   SERADD_OVF_EN  adds output ovf = (carry into MSB) XOR cout, latched when
//                  the MSB window is sampled and held with the result.
//
// Ports:
//   CLK, NRST            clock, synchronous active-low reset
//   req_valid/req_ready  operand request handshake (ready only in IDLE)
//   op_a, op_b, cin_init operands and bit-0 carry-in, captured on accept
//   res_valid/res_ready  result handshake (valid held in DONE)
//   sum, cout            reassembled sum and final carry-out
//   ovf                  signed overflow (SERADD_OVF_EN only)
//   slc_rst, slc_start   slice clear / start pulses
//   slc_a, slc_b, slc_cin current bit pair and carry-in to the slice
//   slc_s, slc_cout      slice registered sum bit and carry-out
// -----------------------------------------------------------------------------
module serial_add_driver
  import serial_add_pkg::*;
#(
  parameter int W       = W_DEFAULT,
  parameter int BIT_CYC = BIT_CYC_DEFAULT
) (
  input  logic         CLK,
  input  logic         NRST,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         cin_init,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] sum,
  output logic         cout,
`ifdef SERADD_OVF_EN
  output logic         ovf,
`endif
  output logic         slc_rst,
  output logic         slc_start,
  output logic         slc_a,
  output logic         slc_b,
  output logic         slc_cin,
  input  logic         slc_s,
  input  logic         slc_cout
);

  localparam int BW = clog2(W);
  localparam int CW = clog2(BIT_CYC);
  localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);
  localparam logic [CW-1:0] WIN_LAST = CW'(BIT_CYC - 1);

  localparam logic [2:0] IDLE  = ST_IDLE;
  localparam logic [2:0] CLEAR = ST_CLEAR;
  localparam logic [2:0] ARM   = ST_ARM;
  localparam logic [2:0] SHIFT = ST_SHIFT;
  localparam logic [2:0] DONE  = ST_DONE;

  logic [2:0]    state_r;
  logic [2:0]    state_nxt_s;
  logic [BW-1:0] bit_cnt_r;
  logic [CW-1:0] win_cnt_r;
  logic          carry_r;
  logic          req_ready_r;
  logic          res_valid_r;
  logic          slc_rst_r;
  logic          slc_start_r;
  logic          slc_a_r;
  logic          slc_b_r;
  logic          slc_cin_r;

  logic          accept_s;
  logic          sample_s;
  logic          last_s;
  logic [W-1:0]  a_q_s;
  logic [W-1:0]  b_q_s;
  logic [W-1:0]  sum_q_s;
  logic          unused_op_s;

  // Window 0 starts in ARM with win_cnt=0, so the first sample is always in SHIFT.
  assign accept_s = req_valid && (state_r == IDLE);
  assign sample_s = (state_r == SHIFT) && (win_cnt_r == WIN_LAST);
  assign last_s   = sample_s && (bit_cnt_r == BIT_LAST);

  // Operand bits only ever leave through the low end of the shift registers.
  assign unused_op_s = ^{a_q_s, b_q_s};

  ser_shift_reg #(.W(W)) u_a_sr (
    .clk   (CLK),
    .nrst  (NRST),
    .load  (accept_s),
    .din   (op_a),
    .shift (sample_s),
    .sin   (1'b0),
    .q     (a_q_s)
  );

  ser_shift_reg #(.W(W)) u_b_sr (
    .clk   (CLK),
    .nrst  (NRST),
    .load  (accept_s),
    .din   (op_b),
    .shift (sample_s),
    .sin   (1'b0),
    .q     (b_q_s)
  );

  // Sum bits arrive LSB first, so after W shifts bit 0 has reached the LSB.
  ser_shift_reg #(.W(W)) u_sum_sr (
    .clk   (CLK),
    .nrst  (NRST),
    .load  (accept_s),
    .din   ({W{1'b0}}),
    .shift (sample_s),
    .sin   (slc_s),
    .q     (sum_q_s)
  );

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) state_nxt_s = CLEAR;
        else           state_nxt_s = IDLE;
      end
      CLEAR: state_nxt_s = ARM;
      ARM:   state_nxt_s = SHIFT;
      SHIFT: begin
        if (last_s) state_nxt_s = DONE;
        else        state_nxt_s = SHIFT;
      end
      DONE: begin
        if (res_ready) state_nxt_s = IDLE;
        else           state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register plus handshake and one-cycle slice control outputs, all decoded from next state
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      state_r     <= IDLE;
      req_ready_r <= 1'b1;
      res_valid_r <= 1'b0;
      slc_rst_r   <= 1'b0;
      slc_start_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      req_ready_r <= (state_nxt_s == IDLE);
      res_valid_r <= (state_nxt_s == DONE);
      slc_rst_r   <= (state_nxt_s == CLEAR);
      slc_start_r <= (state_nxt_s == ARM);
    end
  end

  // Bit and window counters; win_cnt keeps counting from ARM into SHIFT
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      bit_cnt_r <= '0;
      win_cnt_r <= '0;
    end else if (accept_s) begin
      bit_cnt_r <= '0;
      win_cnt_r <= '0;
    end else if (state_r == ARM) begin
      bit_cnt_r <= bit_cnt_r;
      win_cnt_r <= win_cnt_r + 1'b1;
    end else if (state_r == SHIFT) begin
      if (sample_s) begin
        bit_cnt_r <= last_s ? '0 : bit_cnt_r + 1'b1;
        win_cnt_r <= '0;
      end else begin
        bit_cnt_r <= bit_cnt_r;
        win_cnt_r <= win_cnt_r + 1'b1;
      end
    end else begin
      bit_cnt_r <= bit_cnt_r;
      win_cnt_r <= win_cnt_r;
    end
  end

  // Carry register: cin_init on accept, slice carry at every window sample
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      carry_r <= 1'b0;
    end else if (accept_s) begin
      carry_r <= cin_init;
    end else if (sample_s) begin
      carry_r <= slc_cout;
    end else begin
      carry_r <= carry_r;
    end
  end

  // Slice bit pair / carry-in: set up for window 0 during CLEAR, advanced at each sample, zero outside windows
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      slc_a_r   <= 1'b0;
      slc_b_r   <= 1'b0;
      slc_cin_r <= 1'b0;
    end else if (state_r == CLEAR) begin
      slc_a_r   <= a_q_s[0];
      slc_b_r   <= b_q_s[0];
      slc_cin_r <= carry_r;
    end else if (sample_s && !last_s) begin
      // Operand registers shift on this same edge, so the next bit is at [1].
      slc_a_r   <= a_q_s[1];
      slc_b_r   <= b_q_s[1];
      slc_cin_r <= slc_cout;
    end else if ((state_r == ARM) || ((state_r == SHIFT) && !sample_s)) begin
      slc_a_r   <= slc_a_r;
      slc_b_r   <= slc_b_r;
      slc_cin_r <= slc_cin_r;
    end else begin
      slc_a_r   <= 1'b0;
      slc_b_r   <= 1'b0;
      slc_cin_r <= 1'b0;
    end
  end

`ifdef SERADD_OVF_EN
  logic ovf_r;

  // Overflow: carry into the MSB (still in carry_r) XOR carry out of the MSB
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      ovf_r <= 1'b0;
    end else if (last_s) begin
      ovf_r <= carry_r ^ slc_cout;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign ovf = ovf_r;
`endif

  assign req_ready = req_ready_r;
  assign res_valid = res_valid_r;
  assign sum       = sum_q_s;
  assign cout      = carry_r;
  assign slc_rst   = slc_rst_r;
  assign slc_start = slc_start_r;
  assign slc_a     = slc_a_r;
  assign slc_b     = slc_b_r;
  assign slc_cin   = slc_cin_r;

endmodule

// File: tb/tb_serial_add_driver.sv
// -----------------------------------------------------------------------------
// tb_serial_add_driver
// Directed bench for serial_add_driver (W=8, BIT_CYC=3) with a behavioural
// bit-serial adder slice. Expected results are pushed to a scoreboard queue
// at accept time and popped when res_valid rises. Define SERADD_OVF_EN to
// also check the ovf output.
// -----------------------------------------------------------------------------
module tb_serial_add_driver;

  localparam int W       = 8;
  localparam int BIT_CYC = 3;
  localparam int LAT     = 2 + W * BIT_CYC;

  typedef struct packed {
    logic [7:0] s;
    logic       c;
    logic       o;
  } exp_t;

  logic       CLK = 1'b0;
  logic       NRST = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] op_a = 8'h00;
  logic [7:0] op_b = 8'h00;
  logic       cin_init = 1'b0;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;
  logic       slc_rst, slc_start, slc_a, slc_b, slc_cin;
  logic       slc_s, slc_cout, slc_armed;

  int   n_checks = 0;
  int   n_fails  = 0;
  exp_t sb_q[$];

`ifndef SERADD_OVF_EN
  assign ovf = 1'b0;
`endif

  serial_add_driver #(.W(W), .BIT_CYC(BIT_CYC)) dut (
    .CLK       (CLK),
    .NRST      (NRST),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .cin_init  (cin_init),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .sum       (sum),
    .cout      (cout),
`ifdef SERADD_OVF_EN
    .ovf       (ovf),
`endif
    .slc_rst   (slc_rst),
    .slc_start (slc_start),
    .slc_a     (slc_a),
    .slc_b     (slc_b),
    .slc_cin   (slc_cin),
    .slc_s     (slc_s),
    .slc_cout  (slc_cout)
  );

  always #5 CLK = ~CLK;

  // Behavioural slice: full adder with registered S/COUT, active after start
  always_ff @(posedge CLK) begin
    if (!NRST || slc_rst) begin
      slc_armed <= 1'b0;
      slc_s     <= 1'b0;
      slc_cout  <= 1'b0;
    end else if (slc_start || slc_armed) begin
      slc_armed <= 1'b1;
      slc_s     <= slc_a ^ slc_b ^ slc_cin;
      slc_cout  <= (slc_a & slc_b) | (slc_cin & (slc_a ^ slc_b));
    end else begin
      slc_armed <= slc_armed;
      slc_s     <= slc_s;
      slc_cout  <= slc_cout;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_slc_quiet(input string tag);
    check({tag, "_slc_rst"},   32'(slc_rst),   32'd0);
    check({tag, "_slc_start"}, 32'(slc_start), 32'd0);
    check({tag, "_slc_a"},     32'(slc_a),     32'd0);
    check({tag, "_slc_b"},     32'(slc_b),     32'd0);
    check({tag, "_slc_cin"},   32'(slc_cin),   32'd0);
  endtask

  // Carry into bit k of a+b+ci, from the arithmetic sum of the low k bits
  function automatic logic carry_into(input logic [7:0] a, input logic [7:0] b,
                                      input logic ci, input int k);
    logic [8:0] t;
    logic [7:0] m;
    m = (8'd1 << k) - 8'd1;
    t = {1'b0, a & m} + {1'b0, b & m} + {8'd0, ci};
    return t[k];
  endfunction

  // One request: hold = cycles to keep res_ready low in DONE,
  // abort_n = cycle after accept at which NRST is pulsed (0 = none),
  // rr_early = res_ready already high while the result is computed.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input int hold, input int abort_n, input bit rr_early);
    logic [8:0] full;
    exp_t       e;
    exp_t       got;
    int         n;
    int         k;
    full = {1'b0, a} + {1'b0, b} + {8'd0, ci};
    e.s  = full[7:0];
    e.c  = full[8];
    e.o  = carry_into(a, b, ci, 7) ^ full[8];
    check("req_ready_idle", 32'(req_ready), 32'd1);
    op_a      = a;
    op_b      = b;
    cin_init  = ci;
    req_valid = 1'b1;
    res_ready = rr_early;
    sb_q.push_back(e);
    @(negedge CLK);
    req_valid = 1'b0;
    op_a      = 8'h00;
    op_b      = 8'h00;
    cin_init  = 1'b0;
    n = 1;
    while (res_valid !== 1'b1 && n < 60) begin
      if (abort_n != 0 && n == abort_n) begin
        NRST = 1'b0;
        @(negedge CLK);
        check("abort_req_ready", 32'(req_ready), 32'd1);
        check("abort_res_valid", 32'(res_valid), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        check_slc_quiet("abort");
        NRST = 1'b1;
        void'(sb_q.pop_back());
        for (int i = 0; i < 3; i++) begin
          @(negedge CLK);
          check("post_abort_res_valid", 32'(res_valid), 32'd0);
          check_slc_quiet("post_abort");
        end
        return;
      end
      check("req_ready_busy", 32'(req_ready), 32'd0);
      if (n == 1) begin
        check("clear_slc_rst", 32'(slc_rst), 32'd1);
        check("clear_slc_start", 32'(slc_start), 32'd0);
        check("clear_slc_a", 32'(slc_a), 32'd0);
        check("clear_slc_cin", 32'(slc_cin), 32'd0);
      end else begin
        k = (n - 2) / BIT_CYC;
        check("win_slc_rst", 32'(slc_rst), 32'd0);
        check("win_slc_start", 32'(slc_start), (n == 2) ? 32'd1 : 32'd0);
        if (k < W) begin
          check("win_slc_a", 32'(slc_a), 32'(a[k]));
          check("win_slc_b", 32'(slc_b), 32'(b[k]));
          check("win_slc_cin", 32'(slc_cin), 32'(carry_into(a, b, ci, k)));
        end
      end
      @(negedge CLK);
      n++;
    end
    check("latency", 32'(n), 32'(LAT));
    check_slc_quiet("done");
    check("done_req_ready", 32'(req_ready), 32'd0);
    if (sb_q.size() > 0) begin
      got = sb_q.pop_front();
      check("sum", 32'(sum), 32'(got.s));
      check("cout", 32'(cout), 32'(got.c));
`ifdef SERADD_OVF_EN
      check("ovf", 32'(ovf), 32'(got.o));
`endif
    end else begin
      check("scoreboard_nonempty", 32'd0, 32'd1);
    end
    if (rr_early) begin
      @(negedge CLK);
      res_ready = 1'b0;
      check("early_res_valid", 32'(res_valid), 32'd0);
      check("early_req_ready", 32'(req_ready), 32'd1);
      return;
    end
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      op_a      = 8'hA5;
      op_b      = 8'h5A;
      @(negedge CLK);
      check("hold_res_valid", 32'(res_valid), 32'd1);
      check("hold_req_ready", 32'(req_ready), 32'd0);
      check("hold_sum", 32'(sum), 32'(e.s));
      check("hold_cout", 32'(cout), 32'(e.c));
      check("hold_slc_rst", 32'(slc_rst), 32'd0);
    end
    req_valid = 1'b0;
    op_a      = 8'h00;
    op_b      = 8'h00;
    res_ready = 1'b1;
    @(negedge CLK);
    res_ready = 1'b0;
    check("hs_res_valid", 32'(res_valid), 32'd0);
    check("hs_req_ready", 32'(req_ready), 32'd1);
    check_slc_quiet("hs");
  endtask

  initial begin
    NRST = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
`ifdef SERADD_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    check_slc_quiet("rst");
    NRST = 1'b1;
    @(negedge CLK);

    run_op(8'h5A, 8'h33, 1'b0, 0, 0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 0, 0, 1'b0);
    run_op(8'h00, 8'h00, 1'b1, 0, 0, 1'b1);
    run_op(8'h12, 8'h34, 1'b0, 10, 0, 1'b0);
    run_op(8'hC3, 8'h5A, 1'b1, 0, 2 + 4 * BIT_CYC + 1, 1'b0);
    run_op(8'h10, 8'h20, 1'b0, 0, 0, 1'b0);
`ifdef SERADD_OVF_EN
    run_op(8'h7F, 8'h01, 1'b0, 0, 0, 1'b0);
    run_op(8'h80, 8'h80, 1'b0, 0, 0, 1'b0);
    run_op(8'h01, 8'h01, 1'b0, 0, 0, 1'b0);
`endif
    for (int i = 0; i < 4; i++) begin
      run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), 2, 0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/serial_add_driver.md
# serial_add_driver

Initiator side of the bit-serial adder slice interface. Accepts a pair of parallel W-bit operands through a valid/ready request port and clears, arms and feeds the slice one bit pair per bit window, LSB first. It samples the slice's registered sum and carry, closes the carry loop onto the slice's carry input, and reassembles the parallel sum and carry-out on a held result port. It sits between a parallel datapath and one serial adder slice.

## Interface
- W, 8, operand/sum width (≥2)
- BIT_CYC, 3, cycles per bit window (≥2); slice outputs are valid in the last cycle of each window
- CLK  in  1  clock
- NRST  in  1  synchronous active-low reset, sampled on CLK rising edge
- req_valid  in  1  operand request valid
- req_ready  out  1  driver can accept a request
- op_a, op_b  in  W  operands, captured on accept
- cin_init  in  1  carry-in for bit 0, captured on accept
- res_valid  out  1  result held valid
- res_ready  in  1  result consumed
- sum  out  W  reassembled sum
- cout  out  1  final carry-out
- slc_rst  out  1  slice clear, to slice rst
- slc_start  out  1  slice start pulse, to slice start
- slc_a, slc_b, slc_cin  out  1  current bit pair and carry-in, to slice A/B/CIN
- slc_s, slc_cout  in  1  slice registered S/COUT

## Operation
- States: IDLE, CLEAR, ARM, SHIFT, DONE.
- IDLE: req_ready=1. On req_valid&req_ready, capture op_a, op_b and cin_init into shift/carry registers, bit_cnt=0, win_cnt=0, then go to CLEAR.
- CLEAR: slc_rst=1 for exactly one cycle, then go to ARM.
- ARM: slc_start=1 for exactly one cycle. slc_a/slc_b carry bit 0 and slc_cin=cin_init. Then go to SHIFT. This cycle is cycle 0 of window 0.
- SHIFT: win_cnt counts 0..BIT_CYC-1 and is held across ARM→SHIFT. At win_cnt=BIT_CYC-1: shift slc_s into sum from the MSB side (shift right), load the carry register from slc_cout, shift the operand registers right, bit_cnt+1, win_cnt=0. After window W-1 is sampled, go to DONE.
- slc_a/slc_b/slc_cin are driven from registers and are stable for a whole window. slc_cin always equals the carry register.
- DONE: res_valid=1. sum and cout=carry register are held. On res_ready, go to IDLE.
- slc_rst, slc_start, slc_a, slc_b and slc_cin are 0 outside the windows listed above.
- Arithmetic: sum = (op_a+op_b+cin_init) mod 2^W. cout = bit W of the same sum.

## Timing
- Reset (NRST=0 at an edge): state=IDLE. req_ready=1. res_valid=0. sum=0. cout=0. All slc_* outputs are 0. Reset mid-operation aborts immediately, with no result and no slc_rst pulse.
- Latency from the accept edge to res_valid=1: 2+W·BIT_CYC cycles (26 for W=8, BIT_CYC=3).
- req_ready=0 from CLEAR through DONE. There is no pipelining: one request in flight at a time.
- res_valid&res_ready in DONE: IDLE on the next edge. A new request can be accepted in the cycle after that.
- res_ready is ignored when res_valid=0. req_valid is ignored outside IDLE.

## Configuration
- SERADD_OVF_EN defined: adds output ovf (1 bit) = carry into MSB XOR cout. It is latched when the MSB window is sampled, is 0 at reset, and is held with res_valid.
- Not defined: no ovf port and no extra register.

## Structure
- Package serial_add_pkg: state enum (IDLE, CLEAR, ARM, SHIFT, DONE), default W and BIT_CYC constants, and the bit-counter width function clog2(W).
- One natural sub-module, ser_shift_reg: a W-bit right shift register with parallel load, serial in at the MSB and serial out at the LSB. It is instanced three times, for op_a, op_b and sum.

## Test plan
- W=8, 0x5A+0x33, cin_init=0 -> sum=0x8D, cout=0, res_valid exactly 26 cycles after accept.
- 0xFF+0x01, cin_init=0 -> sum=0x00, cout=1; slc_cin=1 from window 1 onward.
- 0x00+0x00, cin_init=1 -> sum=0x01, cout=0; slc_start high for exactly one cycle with slc_cin=1.
- Hold res_ready=0 for 10 cycles in DONE -> sum/cout stable, req_ready=0, second req_valid not accepted until after the handshake.
- NRST=0 during window 4 -> next cycle IDLE, all slc_* outputs 0, res_valid=0; a following 0x10+0x20 request -> 0x30.
- SERADD_OVF_EN: 0x7F+0x01 -> ovf=1; 0x80+0x80 -> sum=0x00, cout=1, ovf=1; 0x01+0x01 -> ovf=0.
